// File: rtl/floor_display_ctrl.sv
// Clocked car-position display: two-digit floor number, direction glyph, door lamps,
// arrival blink/pulse and glitch-filtered fault display. Optional blink: FLOOR_DISPLAY_BLINK_EN.
module floor_display_ctrl #(
    parameter int                    NUM_FLOORS  = 6,
    parameter logic [NUM_FLOORS-1:0] EAST_MASK   = 6'b100111,
    parameter logic [NUM_FLOORS-1:0] WEST_MASK   = 6'b110101,
    parameter int                    BLINK_HALF  = 25_000_000,
    parameter int                    BLINK_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor,
    input  logic [1:0]            direction,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic                  EAST,
    output logic                  WEST,
    output logic [1:0]            up_down,
    output logic                  arrived
);

    localparam int IDX_W = $clog2(NUM_FLOORS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    if (NUM_FLOORS < 2 || NUM_FLOORS > 99 || BLINK_HALF < 1 || BLINK_COUNT < 1) begin : g_param_check
        $error("floor_display_ctrl: parameter out of legal range");
    end

`ifdef FLOOR_DISPLAY_BLINK_EN
    localparam int HCNT_W = $clog2(BLINK_HALF + 1);
    localparam int PCNT_W = $clog2(2 * BLINK_COUNT + 1);
    typedef enum logic [1:0] {IDLE, BLINK, FAULT} state_t;
    logic [HCNT_W-1:0] hcnt, hcnt_d;
    logic [PCNT_W-1:0] pcnt, pcnt_d;
`else
    typedef enum logic [1:0] {IDLE, FAULT} state_t;
`endif

    state_t                state, state_d;
    logic [NUM_FLOORS-1:0] floor_q;
    logic [IDX_W-1:0]      cur_idx, cur_idx_d;
    logic                  inv_cnt, inv_cnt_d;
    logic                  arrived_d;

    logic                  seen_one, seen_many, floor_valid;
    logic [IDX_W-1:0]      floor_idx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // One-hot check: valid only when exactly one bit of the sampled bus is set.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        seen_one  = 1'b0;
        seen_many = 1'b0;
        floor_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_q[i]) begin
                seen_many = seen_one;
                seen_one  = 1'b1;
                floor_idx = IDX_W'(i);
            end
        end
        floor_valid = seen_one && !seen_many;
    end

    always_comb begin
        state_d   = state;
        cur_idx_d = cur_idx;
        inv_cnt_d = inv_cnt;
        arrived_d = 1'b0;
`ifdef FLOOR_DISPLAY_BLINK_EN
        hcnt_d    = hcnt;
        pcnt_d    = pcnt;
`endif
        if (floor_valid) begin
            inv_cnt_d = 1'b0;
            if (floor_idx != cur_idx) begin
                cur_idx_d = floor_idx;
                arrived_d = 1'b1;
`ifdef FLOOR_DISPLAY_BLINK_EN
                state_d   = BLINK;
                hcnt_d    = '0;
                pcnt_d    = '0;
`else
                state_d   = IDLE;
`endif
            end else begin
                case (state)
                    FAULT: state_d = IDLE;
`ifdef FLOOR_DISPLAY_BLINK_EN
                    BLINK: begin
                        if (hcnt == HCNT_W'(BLINK_HALF - 1)) begin
                            hcnt_d = '0;
                            pcnt_d = pcnt + PCNT_W'(1);
                            if (pcnt_d == PCNT_W'(2 * BLINK_COUNT)) state_d = IDLE;
                        end else begin
                            hcnt_d = hcnt + HCNT_W'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end else if (!inv_cnt) begin
            // First bad sample only arms the filter; everything else holds.
            inv_cnt_d = 1'b1;
        end else begin
            state_d = FAULT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            floor_q <= '0;
            up_down <= 2'b00;
            cur_idx <= '0;
            inv_cnt <= 1'b0;
            arrived <= 1'b0;
`ifdef FLOOR_DISPLAY_BLINK_EN
            hcnt    <= '0;
            pcnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            state   <= state_d;
            floor_q <= floor;
            up_down <= direction;
            cur_idx <= cur_idx_d;
            inv_cnt <= inv_cnt_d;
            arrived <= arrived_d;
`ifdef FLOOR_DISPLAY_BLINK_EN
            hcnt    <= hcnt_d;
            pcnt    <= pcnt_d;
`endif
        end
    end

    logic [6:0] num;
    logic [3:0] tens, ones;

    always_comb begin
        num  = 7'(cur_idx) + 7'd1;
        tens = 4'(num / 7'd10);
        ones = 4'(num % 7'd10);
        HEX0 = seg7(ones);
        HEX1 = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
        EAST = EAST_MASK[cur_idx];
        WEST = WEST_MASK[cur_idx];
        if (state == FAULT) begin
            HEX1 = SEG_E;
            HEX0 = SEG_BLANK;
            EAST = 1'b0;
            WEST = 1'b0;
        end
`ifdef FLOOR_DISPLAY_BLINK_EN
        else if (state == BLINK && !pcnt[0]) begin
            HEX0 = SEG_BLANK;
            HEX1 = SEG_BLANK;
        end
`endif
        case (up_down)
            2'b10:   HEX2 = 7'b1111110;
            2'b01:   HEX2 = 7'b1110111;
            2'b11:   HEX2 = 7'b0111111;
            default: HEX2 = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_floor_display_ctrl.sv
// Directed bench for floor_display_ctrl: 6-floor and 12-floor instances, scoreboard of
// expected display vectors; expectations follow FLOOR_DISPLAY_BLINK_EN when it is defined.
module tb_floor_display_ctrl;

`ifdef FLOOR_DISPLAY_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  floor6;
    logic [11:0] floor12;
    logic [1:0]  direction;

    logic [6:0]  hex0_a, hex1_a, hex2_a, hex0_b, hex1_b, hex2_b;
    logic        east_a, west_a, arr_a, east_b, west_b, arr_b;
    logic [1:0]  ud_a, ud_b;

    always #5 clk = ~clk;

    floor_display_ctrl #(
        .NUM_FLOORS(6), .EAST_MASK(6'b100111), .WEST_MASK(6'b110101),
        .BLINK_HALF(4), .BLINK_COUNT(2)
    ) dut (
        .clk(clk), .reset(reset), .floor(floor6), .direction(direction),
        .HEX0(hex0_a), .HEX1(hex1_a), .HEX2(hex2_a), .EAST(east_a), .WEST(west_a),
        .up_down(ud_a), .arrived(arr_a)
    );

    floor_display_ctrl #(
        .NUM_FLOORS(12), .EAST_MASK(12'h801), .WEST_MASK(12'h200),
        .BLINK_HALF(4), .BLINK_COUNT(2)
    ) dut12 (
        .clk(clk), .reset(reset), .floor(floor12), .direction(direction),
        .HEX0(hex0_b), .HEX1(hex1_b), .HEX2(hex2_b), .EAST(east_b), .WEST(west_b),
        .up_down(ud_b), .arrived(arr_b)
    );

    typedef struct {
        string       tag;
        bit          sel12;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: dig = 7'b1000000;  1: dig = 7'b1111001;  2: dig = 7'b0100100;
            3: dig = 7'b0110000;  4: dig = 7'b0011001;  5: dig = 7'b0010010;
            6: dig = 7'b0000010;  7: dig = 7'b1111000;  8: dig = 7'b0000000;
            9: dig = 7'b0010000;  default: dig = BLANK;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input logic [1:0] ud);
        case (ud)
            2'b10:   glyph = 7'b1111110;
            2'b01:   glyph = 7'b1110111;
            2'b11:   glyph = 7'b0111111;
            default: glyph = BLANK;
        endcase
    endfunction

    // Expected vector {HEX2, HEX1, HEX0, EAST, WEST, arrived, up_down} for floor number n.
    function automatic logic [25:0] disp(input int n, input bit blank, input logic e, input logic w,
                                         input logic a, input logic [1:0] ud);
        logic [6:0] h1, h0;
        h1 = (n < 10) ? BLANK : dig(n / 10);
        h0 = dig(n % 10);
        if (blank) begin
            h1 = BLANK;
            h0 = BLANK;
        end
        return {glyph(ud), h1, h0, e, w, a, ud};
    endfunction

    function automatic logic [25:0] fault_disp(input logic [1:0] ud);
        return {glyph(ud), 7'b0000110, BLANK, 1'b0, 1'b0, 1'b0, ud};
    endfunction

    task automatic push(input string tag, input bit sel12, input logic [25:0] v);
        exp_t e;
        e.tag   = tag;
        e.sel12 = sel12;
        e.v     = v;
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [25:0] obs;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed no entry, required one");
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.sel12 ? {hex2_b, hex1_b, hex0_b, east_b, west_b, arr_b, ud_b}
                          : {hex2_a, hex1_a, hex0_a, east_a, west_a, arr_a, ud_a};
            assert (obs === e.v) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_next();
    endtask

    initial begin
        reset     = 1'b1;
        floor6    = 6'b000001;
        floor12   = 12'h001;
        direction = 2'b00;
        #3;
        push("reset_6", 1'b0, disp(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        check_next();
        push("reset_12", 1'b1, disp(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        check_next();

        // Scenario 1: first valid floor equals index 0, no arrival.
        @(negedge clk);
        reset     = 1'b0;
        direction = 2'b10;
        for (int i = 0; i < 3; i++) begin
            push("s1_floor1", 1'b0, disp(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
            tick_check();
        end

        // Scenario 2: arrival at floor 3 with blink.
        floor6 = 6'b000100;
        push("s2_latency", 1'b0, disp(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        for (int i = 0; i < 16; i++)
            push("s2_blink", 1'b0, disp(3, BLINK_ON && ((i / 4) % 2 == 0), 1'b1, 1'b1, (i == 0), 2'b10));
        push("s2_idle", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        for (int i = 0; i < 18; i++) tick_check();

        // Direction glyphs.
        direction = 2'b01;
        push("dir_down", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
        tick_check();
        direction = 2'b11;
        push("dir_invalid", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11));
        tick_check();
        direction = 2'b00;
        push("dir_idle", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        tick_check();
        direction = 2'b10;

        // Scenario 3a: single-cycle glitch (two bits set) is filtered.
        floor6 = 6'b000110;
        push("s3_glitch_e1", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();
        floor6 = 6'b000100;
        push("s3_glitch_e2", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();
        push("s3_glitch_e3", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();

        // Scenario 3b: two-cycle empty bus reaches FAULT, return to same floor clears it.
        floor6 = 6'b000000;
        push("s3_fault_e1", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();
        push("s3_fault_e2", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();
        floor6 = 6'b000100;
        push("s3_fault", 1'b0, fault_disp(2'b10));
        tick_check();
        push("s3_recover", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tick_check();

        // Scenario 5: new arrival during blink phase 1, then asynchronous reset.
        floor6 = 6'b000010;
        push("s5_latency", 1'b0, disp(3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        push("s5_arrive2", 1'b0, disp(2, BLINK_ON, 1'b1, 1'b0, 1'b1, 2'b10));
        for (int i = 0; i < 3; i++)
            push("s5_off2", 1'b0, disp(2, BLINK_ON, 1'b1, 1'b0, 1'b0, 2'b10));
        push("s5_on2", 1'b0, disp(2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10));
        for (int i = 0; i < 6; i++) tick_check();
        floor6 = 6'b100000;
        push("s5_on2_hold", 1'b0, disp(2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10));
        push("s5_restart6", 1'b0, disp(6, BLINK_ON, 1'b1, 1'b1, 1'b1, 2'b10));
        push("s5_off6", 1'b0, disp(6, BLINK_ON, 1'b1, 1'b1, 1'b0, 2'b10));
        for (int i = 0; i < 3; i++) tick_check();
        floor6 = 6'b000001;
        #2;
        reset = 1'b1;
        #1;
        push("s5_async_reset", 1'b0, disp(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        check_next();

        // Scenario 4: two-digit numbers on the 12-floor instance.
        @(negedge clk);
        reset   = 1'b0;
        floor12 = 12'h800;
        repeat (20) @(negedge clk);
        push("s4_twelve", 1'b1, disp(12, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10));
        check_next();
        push("s4_floor1_after_reset", 1'b0, disp(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        check_next();
        floor12 = 12'h200;
        repeat (20) @(negedge clk);
        push("s4_ten", 1'b1, disp(10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
        check_next();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
